// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer arbiter: image geometry, RAM
// widths, FSM state encoding and a bounds helper.
package fb_pkg;

  localparam int c_img_cols = 320;
  localparam int c_img_rows = 240;
  localparam int c_nb_addr  = 17;
  localparam int c_nb_pxl   = 8;
  localparam int c_img_pxls = c_img_cols * c_img_rows;   // 76800

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_rd   = 2'd1;
  localparam logic [1:0] c_st_cap  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = c_st_idle,
    S_RD   = c_st_rd,
    S_CAP  = c_st_cap
  } fb_state_t;

  // True when a frame-buffer address lies inside the stored image.
  function automatic logic addr_in_range(input logic [c_nb_addr-1:0] a);
    return (a < c_nb_addr'(c_img_pxls));
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter and its environment:
// VGA timing in, camera write handshake, RAM port and display pixel out.
interface fb_arbiter_if;
  import fb_pkg::*;

  logic [9:0]           vga_col;
  logic [9:0]           vga_row;
  logic                 vga_visible;
  logic                 vga_new_pxl;
  logic                 cam_valid;
  logic [c_nb_addr-1:0] cam_addr;
  logic [c_nb_pxl-1:0]  cam_data;
  logic                 cam_ready;
  logic [c_nb_addr-1:0] mem_addr;
  logic                 mem_we;
  logic [c_nb_pxl-1:0]  mem_wdata;
  logic [c_nb_pxl-1:0]  mem_rdata;
  logic [c_nb_pxl-1:0]  disp_pxl;
  logic                 wr_err;

  // Arbiter side.
  modport slave (
    input  vga_col, vga_row, vga_visible, vga_new_pxl,
    input  cam_valid, cam_addr, cam_data, mem_rdata,
    output cam_ready, mem_addr, mem_we, mem_wdata, disp_pxl, wr_err
  );

  // Environment side: VGA timing, camera, RAM and display stage.
  modport master (
    output vga_col, vga_row, vga_visible, vga_new_pxl,
    output cam_valid, cam_addr, cam_data, mem_rdata,
    input  cam_ready, mem_addr, mem_we, mem_wdata, disp_pxl, wr_err
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Column/row to frame-buffer address plus in-image flag, purely
// combinational. Macro FB_SCALE2_EN selects 2x pixel/line replication
// (640x480 screen area); without it the image maps 1:1 in the top-left.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [9:0]           i_col,
  input  logic [9:0]           i_row,
  output logic [c_nb_addr-1:0] o_addr,
  output logic                 o_in_img
);

  logic [9:0]           w_col_img;
  logic [9:0]           w_row_img;
  logic [c_nb_addr-1:0] w_col_ext;
  logic [c_nb_addr-1:0] w_row_ext;

`ifdef FB_SCALE2_EN
  assign w_col_img = {1'b0, i_col[9:1]};
  assign w_row_img = {1'b0, i_row[9:1]};
  assign o_in_img  = (i_col < 10'(c_img_cols + c_img_cols)) &&
                     (i_row < 10'(c_img_rows + c_img_rows));
`else
  assign w_col_img = i_col;
  assign w_row_img = i_row;
  assign o_in_img  = (i_col < 10'(c_img_cols)) && (i_row < 10'(c_img_rows));
`endif

  assign w_col_ext = c_nb_addr'(w_col_img);
  assign w_row_ext = c_nb_addr'(w_row_img);

  // row*320 as row*256 + row*64; out-of-image rows may wrap, the caller
  // qualifies the address with o_in_img.
  assign o_addr = (w_row_ext << 4'd8) + (w_row_ext << 4'd6) + w_col_ext;

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display reads own the RAM port in the cycle
// after each accepted VGA pixel strobe; camera writes go through a 1-entry
// holding register and use any other cycle. All RAM and display outputs
// are registered, so port decisions are taken one cycle ahead using the
// next FSM state. Macro FB_SCALE2_EN (see fb_addr_gen) selects 2x scaling.
module fb_arbiter
  import fb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fb_arbiter_if.slave  bus
);

  fb_state_t            r_state;
  fb_state_t            w_next_state;
  logic [c_nb_addr-1:0] w_pix_addr;
  logic                 w_in_img;
  logic                 w_rd_en;
  logic                 w_rd_next;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_hold_in_rng;

  logic                 r_rd_en;
  logic                 r_cam_ready;
  logic [c_nb_addr-1:0] r_hold_addr;
  logic [c_nb_pxl-1:0]  r_hold_data;
  logic [c_nb_addr-1:0] r_mem_addr;
  logic                 r_mem_we;
  logic [c_nb_pxl-1:0]  r_mem_wdata;
  logic [c_nb_pxl-1:0]  r_disp_pxl;
  logic                 r_wr_err;

  fb_addr_gen u_addr_gen (
    .i_col    (bus.vga_col),
    .i_row    (bus.vga_row),
    .o_addr   (w_pix_addr),
    .o_in_img (w_in_img)
  );

  assign w_rd_en       = bus.vga_visible && w_in_img;
  assign w_rd_next     = (w_next_state == S_RD);
  assign w_accept      = bus.cam_valid && r_cam_ready;
  // Holding register is full (not ready) and next cycle is not a read slot.
  assign w_issue       = !r_cam_ready && !w_rd_next;
  assign w_hold_in_rng = addr_in_range(r_hold_addr);

  // Next-state decode; a strobe seen while in S_RD is ignored.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.vga_new_pxl) w_next_state = S_RD;
        else                 w_next_state = S_IDLE;
      end
      S_RD:   w_next_state = S_CAP;
      S_CAP: begin
        if (bus.vga_new_pxl) w_next_state = S_RD;
        else                 w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM, RAM port scheduling, display capture and write handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rd_en     <= 1'b0;
      r_cam_ready <= 1'b1;
      r_hold_addr <= {c_nb_addr{1'b0}};
      r_hold_data <= {c_nb_pxl{1'b0}};
      r_mem_addr  <= {c_nb_addr{1'b0}};
      r_mem_we    <= 1'b0;
      r_mem_wdata <= {c_nb_pxl{1'b0}};
      r_disp_pxl  <= {c_nb_pxl{1'b0}};
      r_wr_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // RAM port for the coming cycle: a read slot always wins.
      if (w_rd_next) begin
        r_rd_en  <= w_rd_en;
        r_mem_we <= 1'b0;
        if (w_rd_en) begin
          r_mem_addr <= w_pix_addr;
        end
      end else if (w_issue) begin
        r_mem_addr  <= r_hold_addr;
        r_mem_wdata <= r_hold_data;
        r_mem_we    <= w_hold_in_rng;
        if (!w_hold_in_rng) begin
          r_wr_err <= 1'b1;
        end
      end else begin
        r_mem_we <= 1'b0;
      end

      // RAM data for the read issued in S_RD is valid during S_CAP.
      if (r_state == S_CAP) begin
        r_disp_pxl <= r_rd_en ? bus.mem_rdata : {c_nb_pxl{1'b0}};
      end

      // Holding register: fill on handshake, free once handed to the port.
      if (w_accept) begin
        r_cam_ready <= 1'b0;
        r_hold_addr <= bus.cam_addr;
        r_hold_data <= bus.cam_data;
      end else if (w_issue) begin
        r_cam_ready <= 1'b1;
      end
    end
  end

  assign bus.cam_ready = r_cam_ready;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.disp_pxl  = r_disp_pxl;
  assign bus.wr_err    = r_wr_err;

endmodule
